// File: rtl/dmem_responder.sv
// dmem_responder: single-port data-memory responder with programmable wait states.
//
// An access is accepted in IDLE when req=1. Address, direction and write data
// are captured on the accepting edge and the block then ignores its request
// inputs until the access completes. ready pulses for exactly one cycle,
// WAIT_CYCLES+1 cycles after the accepting edge. rd and err are valid only
// while ready=1 and are 0 otherwise.
//
// Storage is DEPTH 32-bit words addressed by a[log2(DEPTH)+1:2]. Misaligned and
// out-of-range accesses complete with err=1, rd=0 and no write.
//
// Optional feature (macro DMEM_RESPONDER_MMIO_EN):
//   0xFFFF_FFF0  free-running cycle counter; a write clears it. A read returns
//                the value the counter holds during the read's ready cycle.
//   0xFFFF_FFF4  completed-access counter (one count per ready pulse, counted
//                as the pulse ends); a write completes with err=1.
// Without the macro both addresses are out of range.
//
// Ports:
//   clk    in   clock, all state changes on the rising edge
//   reset  in   synchronous active-high reset (storage is not cleared)
//   req    in   request valid
//   we     in   1 = write, 0 = read
//   a      in   byte address [31:0]
//   wd     in   write data [31:0]
//   rd     out  read data [31:0]
//   ready  out  one-cycle completion pulse
//   err    out  error flag
module dmem_responder #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DEPTH       = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ready,
  output logic        err
);

  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic        we_lat;
  logic [31:0] a_lat;
  logic [31:0] wd_lat;
  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        finish;
  logic        cur_we;
  logic [31:0] cur_a;
  logic [31:0] cur_wd;
  logic [31:0] word_idx;
  logic [IDX_W-1:0] idx;
  logic        misaligned;
  logic        ram_hit;
  logic        cyc_hit;
  logic        acc_hit;
  logic        fault;
  logic        ram_write;
  logic [31:0] read_val;
  logic [31:0] rd_q;
  logic        err_q;

  assign accept = (state == IDLE) && req;

  // With zero wait states the access finishes on its accepting edge, before
  // the latched copies exist, so the live inputs are used while in IDLE.
  assign cur_we = (state == IDLE) ? we : we_lat;
  assign cur_a  = (state == IDLE) ? a  : a_lat;
  assign cur_wd = (state == IDLE) ? wd : wd_lat;

  assign word_idx   = {2'b00, cur_a[31:2]};
  assign idx        = cur_a[IDX_W+1:2];
  assign misaligned = (cur_a[1:0] != 2'b00);
  assign ram_hit    = !misaligned && (word_idx < DEPTH);

  always_comb begin
    state_next = state;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_next = DONE;
            finish     = 1'b1;
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd1) begin
          state_next = DONE;
          finish     = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef DMEM_RESPONDER_MMIO_EN
  localparam logic [31:0] CYC_ADDR = 32'hFFFF_FFF0;
  localparam logic [31:0] ACC_ADDR = 32'hFFFF_FFF4;

  logic [31:0] cyc_cnt;
  logic [31:0] acc_cnt;

  assign cyc_hit = (cur_a == CYC_ADDR);
  assign acc_hit = (cur_a == ACC_ADDR);

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt <= '0;
      acc_cnt <= '0;
    end else begin
      cyc_cnt <= (finish && cur_we && cyc_hit) ? 32'd0 : cyc_cnt + 32'd1;
      if (state == DONE) begin
        acc_cnt <= acc_cnt + 32'd1;
      end
    end
  end
`else
  assign cyc_hit = 1'b0;
  assign acc_hit = 1'b0;
`endif

  assign fault     = misaligned || !(ram_hit || cyc_hit || acc_hit) || (cur_we && acc_hit);
  assign ram_write = finish && cur_we && ram_hit;

  always_comb begin
    read_val = '0;
    if (!cur_we && !fault) begin
      if (ram_hit) begin
        read_val = mem[idx];
      end
`ifdef DMEM_RESPONDER_MMIO_EN
      // rd is registered on the edge entering DONE; +1 gives the value the
      // counter holds during the DONE cycle itself.
      else if (cyc_hit) begin
        read_val = cyc_cnt + 32'd1;
      end else if (acc_hit) begin
        read_val = acc_cnt;
      end
`endif
    end
  end

  // Stage boundary: request capture on the accepting edge
  always_ff @(posedge clk) begin
    if (accept) begin
      we_lat <= we;
      a_lat  <= a;
      wd_lat <= wd;
    end
  end

  // Stage boundary: storage update on the edge entering DONE
  always_ff @(posedge clk) begin
    if (!reset && ram_write) begin
      mem[idx] <= cur_wd;
    end
  end

  // Stage boundary: control state and registered response
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      rd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        cnt <= WAIT_LOAD;
      end else if (state == BUSY) begin
        cnt <= cnt - 4'd1;
      end
      rd_q  <= finish ? read_val : 32'd0;
      err_q <= finish && fault;
    end
  end

  assign ready = (state == DONE);
  assign rd    = rd_q;
  assign err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: table of directed vectors, random traffic
// against a word-array model, and hand-written multi-cycle sequences
// (zero-wait back-to-back reads, reset abort, MMIO counters).
module tb_dmem_responder;

  localparam int W = 2;
  localparam int D = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic        ready;
  logic        err;

  logic        req0 = 1'b0;
  logic        we0 = 1'b0;
  logic [31:0] a0 = '0;
  logic [31:0] wd0 = '0;
  logic [31:0] rd0;
  logic        ready0;
  logic        err0;

  int checks = 0;
  int errors = 0;
  int unsigned edge_no = 0;

  logic [31:0] mem_model [D];
`ifdef DMEM_RESPONDER_MMIO_EN
  int unsigned zero_edge = 0;
  int unsigned acc_model = 0;
`endif

  typedef struct {
    bit          w;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs [13];

  dmem_responder #(.WAIT_CYCLES(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .a(a), .wd(wd),
    .rd(rd), .ready(ready), .err(err)
  );

  dmem_responder #(.WAIT_CYCLES(0), .DEPTH(D)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .a(a0), .wd(wd0),
    .rd(rd0), .ready(ready0), .err(err0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_no <= edge_no + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the test completed");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_commit(input bit w, input logic [31:0] addr_v, input logic [31:0] data_v,
                              input int unsigned dedge);
    if (w && (addr_v % 4 == 0) && (addr_v / 4 < D)) mem_model[addr_v / 4] = data_v;
`ifdef DMEM_RESPONDER_MMIO_EN
    if (w && addr_v == 32'hFFFF_FFF0) zero_edge = dedge;
    acc_model++;
`else
    if (dedge == 0) begin end
`endif
  endtask

  function automatic void model_expect(input bit w, input logic [31:0] addr_v,
                                       output logic [31:0] e_rd, output bit e_err);
    e_rd  = '0;
    e_err = 1'b0;
    if (addr_v % 4 != 0) e_err = 1'b1;
    else if (addr_v / 4 < D) begin
      if (!w) e_rd = mem_model[addr_v / 4];
    end else e_err = 1'b1;
  endfunction

  // One access on dut; request inputs are scrambled (req kept high) while
  // the access is in flight.
  task automatic do_access(input bit w, input logic [31:0] addr_v, input logic [31:0] data_v,
                           output logic [31:0] got_rd, output logic got_err, output int lat,
                           output int unsigned dedge, output bit clean);
    clean = 1'b1; lat = 0; got_rd = '0; got_err = 1'b0; dedge = 0;
    @(negedge clk);
    req = 1'b1; we = w; a = addr_v; wd = data_v;
    @(posedge clk);
    #1;
    we = 1'($urandom); a = $urandom; wd = $urandom;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        lat = k; got_rd = rd; got_err = err; dedge = edge_no;
        break;
      end
      if (rd !== 32'd0 || err !== 1'b0) clean = 1'b0;
    end
    req = 1'b0;
    @(negedge clk);
    if (ready !== 1'b0 || rd !== 32'd0 || err !== 1'b0) clean = 1'b0;
  endtask

  task automatic run_check(input string name, input bit w, input logic [31:0] addr_v,
                           input logic [31:0] data_v, input logic [31:0] exp_rd, input bit exp_err);
    logic [31:0] got_rd; logic got_err; int lat; int unsigned dedge; bit clean;
    do_access(w, addr_v, data_v, got_rd, got_err, lat, dedge, clean);
    chk($sformatf("%s latency", name), 32'(lat), 32'(W + 1));
    chk($sformatf("%s rd", name), got_rd, exp_rd);
    chk($sformatf("%s err", name), 32'(got_err), 32'(exp_err));
    chk($sformatf("%s quiet outside done", name), 32'(clean), 32'd1);
    model_commit(w, addr_v, data_v, dedge);
  endtask

  initial begin
    logic [31:0] e_rd;
    bit          e_err;
    logic [31:0] addr_v;
    logic [31:0] v0;
    int          pulses;
    int          sel;
    bit          seen;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0013, 32'h0,         32'h0,         1'b1};
    vecs[3]  = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 32'h0,         1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0100, 32'h0000_0001, 32'h0,         1'b1};
    vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_00FC, 32'h1234_5678, 32'h0,         1'b0};
    vecs[7]  = '{1'b0, 32'h0000_00FC, 32'h0,         32'h1234_5678, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0011, 32'hFFFF_FFFF, 32'h0,         1'b1};
    vecs[9]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0102, 32'h0,         32'h0,         1'b1};
    vecs[11] = '{1'b1, 32'hFFFF_FFF8, 32'h0000_ABCD, 32'h0,         1'b1};
    vecs[12] = '{1'b0, 32'h8000_0000, 32'h0,         32'h0,         1'b1};

    // reset and idle outputs
    repeat (3) @(posedge clk);
    #1;
`ifdef DMEM_RESPONDER_MMIO_EN
    zero_edge = edge_no; acc_model = 0;
`endif
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("reset ready", 32'(ready), 32'd0);
    chk("reset rd", rd, 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset ready0", 32'(ready0), 32'd0);
    chk("reset rd0", rd0, 32'd0);
    chk("reset err0", 32'(err0), 32'd0);

    for (int i = 0; i < 13; i++)
      run_check($sformatf("vec%0d", i), vecs[i].w, vecs[i].addr, vecs[i].data,
                vecs[i].exp_rd, vecs[i].exp_err);

    // fill every word, then random mixed traffic against the model
    for (int i = 0; i < D; i++)
      run_check($sformatf("init%0d", i), 1'b1, 32'(i * 4), $urandom, 32'd0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)      addr_v = 32'($urandom_range(0, D - 1)) * 4;
      else if (sel < 9) addr_v = 32'($urandom_range(0, D - 1)) * 4 + 32'($urandom_range(1, 3));
      else              addr_v = 32'h100 + 32'($urandom_range(0, 1000)) * 4;
      model_expect(sel[0], addr_v, e_rd, e_err);
      run_check($sformatf("rand%0d", i), sel[0], addr_v, $urandom, e_rd, e_err);
    end

`ifdef DMEM_RESPONDER_MMIO_EN
    begin
      logic [31:0] got_rd; logic got_err; int lat; int unsigned dedge; bit clean;
      run_check("mmio acc read", 1'b0, 32'hFFFF_FFF4, 32'd0, 32'(acc_model), 1'b0);
      run_check("mmio cyc clear", 1'b1, 32'hFFFF_FFF0, $urandom, 32'd0, 1'b0);
      do_access(1'b0, 32'hFFFF_FFF0, 32'd0, got_rd, got_err, lat, dedge, clean);
      chk("mmio cyc read rd", got_rd, 32'(dedge - zero_edge));
      chk("mmio cyc read err", 32'(got_err), 32'd0);
      chk("mmio cyc read latency", 32'(lat), 32'(W + 1));
      model_commit(1'b0, 32'hFFFF_FFF0, 32'd0, dedge);
      run_check("mmio acc write", 1'b1, 32'hFFFF_FFF4, 32'h55, 32'd0, 1'b1);
      run_check("mmio acc reread", 1'b0, 32'hFFFF_FFF4, 32'd0, 32'(acc_model), 1'b0);
    end
`else
    run_check("mmio off acc read", 1'b0, 32'hFFFF_FFF4, 32'd0, 32'd0, 1'b1);
    run_check("mmio off cyc read", 1'b0, 32'hFFFF_FFF0, 32'd0, 32'd0, 1'b1);
    run_check("mmio off cyc write", 1'b1, 32'hFFFF_FFF0, 32'h1, 32'd0, 1'b1);
`endif

    // zero wait states, req held high: write then four back-to-back reads
    v0 = $urandom;
    pulses = 0;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; a0 = 32'h8; wd0 = v0;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      chk($sformatf("zw ready n%0d", n), 32'(ready0), 32'((n % 2 == 1) && (n <= 9)));
      chk($sformatf("zw err n%0d", n), 32'(err0), 32'd0);
      if (n >= 3 && ready0 === 1'b1) begin
        pulses++;
        chk($sformatf("zw rd n%0d", n), rd0, v0);
      end else begin
        chk($sformatf("zw rd idle n%0d", n), rd0, 32'd0);
      end
      if (n == 1) we0 = 1'b0;
      if (n == 9) req0 = 1'b0;
    end
    chk("zw read pulses", 32'(pulses), 32'd4);

    // reset during BUSY of a write aborts it
    run_check("abort pre-write", 1'b1, 32'h20, 32'h1234_ABCD, 32'd0, 1'b0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; a = 32'h20; wd = 32'h55;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    seen = ready;
    reset = 1'b1;
    @(posedge clk);
    #1;
`ifdef DMEM_RESPONDER_MMIO_EN
    zero_edge = edge_no; acc_model = 0;
`endif
    @(negedge clk); reset = 1'b0;
    seen = seen | ready;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen = seen | ready;
    end
    chk("abort no ready", 32'(seen), 32'd0);
    run_check("abort reread", 1'b0, 32'h20, 32'd0, 32'h1234_ABCD, 1'b0);

    // completed-access counter after five accesses since reset
    run_check("cnt acc2", 1'b0, 32'h10, 32'd0, mem_model[4], 1'b0);
    run_check("cnt acc3", 1'b0, 32'h13, 32'd0, 32'd0, 1'b1);
    run_check("cnt acc4", 1'b1, 32'h0, 32'h0BAD_F00D, 32'd0, 1'b0);
    run_check("cnt acc5", 1'b0, 32'h0, 32'd0, 32'h0BAD_F00D, 1'b0);
`ifdef DMEM_RESPONDER_MMIO_EN
    run_check("acc after five", 1'b0, 32'hFFFF_FFF4, 32'd0, 32'd5, 1'b0);
`else
    run_check("acc after five off", 1'b0, 32'hFFFF_FFF4, 32'd0, 32'd0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the number of wait-state cycles inserted per access (legal range 0..15).
REQ-002 The block SHALL have parameter DEPTH, default 64, meaning the number of 32-bit words of storage.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req, input, 1 bit: request valid from the CPU side.
REQ-006 The block SHALL have port we, input, 1 bit: 1 = write, 0 = read; qualified by req.
REQ-007 The block SHALL have port a, input, 32 bits: byte address.
REQ-008 The block SHALL have port wd, input, 32 bits: write data.
REQ-009 The block SHALL have port rd, output, 32 bits: read data, valid while ready=1.
REQ-010 The block SHALL have port ready, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port err, output, 1 bit: error flag, valid while ready=1.

Function
REQ-012 The block SHALL implement FSM states IDLE, BUSY and DONE.
REQ-013 In IDLE with req=1 at a rising edge, the block SHALL latch a, we and wd, load the wait counter with WAIT_CYCLES, and go to BUSY (or straight to DONE if WAIT_CYCLES=0).
REQ-014 In BUSY, the counter SHALL decrement by 1 per cycle, and the block SHALL go to DONE on the edge where the counter equals 1.
REQ-015 ready SHALL be 1 only in DONE, exactly WAIT_CYCLES+1 cycles after the accepting edge, for exactly one cycle; DONE always goes to IDLE.
REQ-016 req, a, we and wd SHALL be ignored in BUSY and DONE; the latched copies are used.
REQ-017 A req still high in the IDLE cycle after DONE SHALL be accepted as a new access, so the minimum access period is WAIT_CYCLES+2 cycles.
REQ-018 A valid write SHALL update word a[log2(DEPTH)+1:2] on the edge entering DONE.
REQ-019 A valid read SHALL drive that word on rd during DONE.
REQ-020 A valid read-after-write to the same address SHALL return the new data.
REQ-021 A misaligned access (a[1:0]!=0) SHALL complete normally with err=1, rd=0 and no write.
REQ-022 An out-of-range access (word index >= DEPTH and not an enabled MMIO address) SHALL complete normally with err=1, rd=0 and no write.
REQ-023 Outside DONE, rd SHALL be 0 and err SHALL be 0.

Reset
REQ-024 While reset=1 at a rising edge, the block SHALL set state=IDLE, ready=0, err=0, rd=0, wait counter=0 and MMIO counters=0.
REQ-025 Storage contents SHALL NOT be cleared by reset.
REQ-026 Reset asserted during BUSY or DONE SHALL abort the access with no ready pulse; a pending write in BUSY SHALL be discarded.

Configuration
REQ-027 With macro DMEM_RESPONDER_MMIO_EN defined, the following registers SHALL exist:
- 0xFFFF_FFF0: free-running 32-bit cycle counter, +1 every cycle, wraps 0xFFFF_FFFF->0, read-only; a write to it clears it to 0 (cleared value visible next cycle).
- 0xFFFF_FFF4: 32-bit completed-access counter, +1 on each ready pulse including err completions, wraps, read-only; a write to it completes with err=1.
- Accesses to either register use the same wait-state timing as RAM.
REQ-028 Without DMEM_RESPONDER_MMIO_EN, neither counter SHALL exist, and those addresses SHALL be out-of-range (err=1).

Verification
REQ-029 Write then read: WAIT_CYCLES=2; write a=0x10, wd=0xDEADBEEF, then read a=0x10 -> ready 3 cycles after each accept, rd=0xDEADBEEF, err=0.
REQ-030 Zero wait: WAIT_CYCLES=0, req held high for 4 reads -> ready every 2nd cycle, 4 pulses total.
REQ-031 Errors: read a=0x13 -> err=1, rd=0; write a=0x100 with DEPTH=64, wd=0x1 -> err=1, and RAM word 0 is unchanged on re-read.
REQ-032 Reset abort: reset for 1 cycle during BUSY of a write a=0x20, wd=0x55 -> no ready pulse; the earlier value at 0x20 is still read back.
REQ-033 MMIO (macro on): write 0xFFFF_FFF0, then read 0xFFFF_FFF0 -> rd = WAIT_CYCLES+1 plus the cycles from clear to the read's latch; read 0xFFFF_FFF4 after 5 completed accesses -> rd=5.
REQ-034 MMIO off: read 0xFFFF_FFF4 -> err=1, rd=0.
